// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: function codes, instruction
// field positions and FSM state encodings.
package alu_issue_ctrl_pkg;

  // ALU function codes carried in the instruction func field
  typedef enum logic [3:0] {
    FuncAdd = 4'd0,
    FuncSub = 4'd1,
    FuncAnd = 4'd2,
    FuncOr  = 4'd3,
    FuncXor = 4'd4,
    FuncNor = 4'd5,
    FuncSl  = 4'd6,
    FuncSrl = 4'd7,
    FuncSra = 4'd8,
    FuncSlt = 4'd9,
    FuncSgt = 4'd10,
    FuncLui = 4'd11,
    FuncHam = 4'd12
  } func_t;

  localparam logic [3:0] FuncMax     = 4'd12;
  // Opcode the ALU treats as its default case (result 0)
  localparam logic [3:0] FuncIllegal = 4'hF;

  // Instruction field bit positions
  localparam int unsigned FuncMsb = 31;
  localparam int unsigned FuncLsb = 28;
  localparam int unsigned IselBit = 27;
  localparam int unsigned RdMsb   = 26;
  localparam int unsigned RdLsb   = 22;
  localparam int unsigned RsMsb   = 21;
  localparam int unsigned RsLsb   = 17;
  localparam int unsigned RtMsb   = 16;
  localparam int unsigned RtLsb   = 12;
  localparam int unsigned ImmMsb  = 15;
  localparam int unsigned ImmLsb  = 0;

  localparam int unsigned RegAw   = 5;
  localparam int unsigned ImmW    = 16;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t StIdle      = 2'd0;
  localparam state_t StDecode    = 2'd1;
  localparam state_t StExecute   = 2'd2;
  localparam state_t StWriteback = 2'd3;

  // True for func codes the ALU implements
  function automatic logic is_legal(input logic [3:0] func);
    return func <= FuncMax;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the issue controller's instruction handshake, ALU bus,
// retirement and debug-read signals.
interface alu_issue_ctrl_if
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       alu_opcode;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [XLEN-1:0]  alu_result;
  logic             done;
  logic             illegal;
  logic [RegAw-1:0] wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic [RegAw-1:0] dbg_addr;
  logic [XLEN-1:0]  dbg_data;

  // Controller side
  modport master (
    input  instr, instr_valid, alu_result, dbg_addr,
    output instr_ready, alu_opcode, alu_a, alu_b, done, illegal, wb_addr, wb_data, dbg_data
  );

  // Instruction source / ALU / observer side
  modport slave (
    output instr, instr_valid, alu_result, dbg_addr,
    input  instr_ready, alu_opcode, alu_a, alu_b, done, illegal, wb_addr, wb_data, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl_reg_file.sv
// Architectural register file: two async read ports, one debug read port,
// one synchronous write port. r0 always reads zero.
module alu_issue_ctrl_reg_file #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_raddr_a,
  output logic [XLEN-1:0] o_rdata_a,
  input  logic [AW-1:0]   i_raddr_b,
  output logic [XLEN-1:0] o_rdata_b,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_mem [NREGS];

  // Clear all entries on reset; never write r0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accepts an instruction, reads operands,
// drives one ALU operation, and writes the result back.
// Sequence is IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned XLEN  = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_ctrl_if.master    io_bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_instr;
  logic [3:0]       r_alu_opcode;
  logic [XLEN-1:0]  r_alu_a;
  logic [XLEN-1:0]  r_alu_b;
  logic             r_illegal;
  logic [RegAw-1:0] r_wb_addr;
  logic [XLEN-1:0]  r_result;

  logic [3:0]       w_func;
  logic             w_isel;
  logic [RegAw-1:0] w_rd;
  logic [RegAw-1:0] w_rs;
  logic [RegAw-1:0] w_rt;
  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_rdata_a;
  logic [XLEN-1:0]  w_rdata_b;
  logic             w_legal;
  logic             w_we;

  assign w_func  = r_instr[FuncMsb:FuncLsb];
  assign w_isel  = r_instr[IselBit];
  assign w_rd    = r_instr[RdMsb:RdLsb];
  assign w_rs    = r_instr[RsMsb:RsLsb];
  assign w_rt    = r_instr[RtMsb:RtLsb];
  assign w_imm   = {{(XLEN-ImmW){1'b0}}, r_instr[ImmMsb:ImmLsb]};
  assign w_legal = is_legal(w_func);

  // Only legal instructions commit; r0 suppression lives in the register file
  assign w_we = (r_state == StWriteback) && !r_illegal;

  alu_issue_ctrl_reg_file #(
    .NREGS (NREGS),
    .XLEN  (XLEN),
    .AW    (RegAw)
  ) u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .i_raddr_a  (w_rs),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (w_rt),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (io_bus.dbg_addr),
    .o_dbg_data (io_bus.dbg_data),
    .i_we       (w_we),
    .i_waddr    (r_wb_addr),
    .i_wdata    (r_result)
  );

  // Next-state: fixed four-step sequence, leaving IDLE only on a valid instruction
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:      if (io_bus.instr_valid) w_state_nxt = StDecode;
      StDecode:    w_state_nxt = StExecute;
      StExecute:   w_state_nxt = StWriteback;
      StWriteback: w_state_nxt = StIdle;
      default:     w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_instr      <= '0;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_illegal    <= 1'b0;
      r_wb_addr    <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: begin
          if (io_bus.instr_valid) r_instr <= io_bus.instr;
        end
        StDecode: begin
          // ALU inputs change only here, so they hold outside EXECUTE
          r_alu_a      <= w_rdata_a;
          r_alu_b      <= w_isel ? w_imm : w_rdata_b;
          r_alu_opcode <= w_legal ? w_func : FuncIllegal;
          r_illegal    <= !w_legal;
          r_wb_addr    <= w_rd;
        end
        StExecute: begin
          r_result <= r_illegal ? '0 : io_bus.alu_result;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.instr_ready = (r_state == StIdle);
  assign io_bus.done        = (r_state == StWriteback);
  assign io_bus.illegal     = (r_state == StWriteback) && r_illegal;
  assign io_bus.wb_addr     = r_wb_addr;
  assign io_bus.wb_data     = r_result;
  assign io_bus.alu_opcode  = r_alu_opcode;
  assign io_bus.alu_a       = r_alu_a;
  assign io_bus.alu_b       = r_alu_b;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU model.
module tb_alu_issue_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU stand-in for the opcodes this bench exercises
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11:   return b << 16;
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_result = alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);

  function automatic logic [31:0] enc_r(input logic [3:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {f, 1'b0, rd, rs, rt, 12'h000};
  endfunction

  function automatic logic [31:0] enc_i(input logic [3:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {f, 1'b1, rd, rs, 1'b0, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from IDLE and check every stage through the return to IDLE.
  // With keep set, instr_valid stays high with a junk word that must be ignored.
  task automatic run(input string tag, input logic [31:0] word, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                     input logic [31:0] wb, input logic ill, input bit keep);
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    check({tag, ".ready_idle"}, {31'd0, bus.instr_ready}, 32'd1);
    tick();
    if (keep) bus.instr = 32'hE000_0000;
    else      bus.instr_valid = 1'b0;
    check({tag, ".ready_dec"}, {31'd0, bus.instr_ready}, 32'd0);
    check({tag, ".done_dec"},  {31'd0, bus.done},        32'd0);
    tick();
    check({tag, ".ready_ex"}, {31'd0, bus.instr_ready}, 32'd0);
    check({tag, ".done_ex"},  {31'd0, bus.done},        32'd0);
    check({tag, ".opcode"},   {28'd0, bus.alu_opcode},  {28'd0, op});
    check({tag, ".alu_a"},    bus.alu_a,                a);
    check({tag, ".alu_b"},    bus.alu_b,                b);
    tick();
    check({tag, ".ready_wb"}, {31'd0, bus.instr_ready}, 32'd0);
    check({tag, ".done_wb"},  {31'd0, bus.done},        32'd1);
    check({tag, ".illegal"},  {31'd0, bus.illegal},     {31'd0, ill});
    check({tag, ".wb_addr"},  {27'd0, bus.wb_addr},     {27'd0, rd});
    check({tag, ".wb_data"},  bus.wb_data,              wb);
    tick();
    check({tag, ".ready_ret"},   {31'd0, bus.instr_ready}, 32'd1);
    check({tag, ".done_ret"},    {31'd0, bus.done},        32'd0);
    check({tag, ".illegal_ret"}, {31'd0, bus.illegal},     32'd0);
  endtask

  task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      check_reg($sformatf("%s.r%0d", tag, i), 5'(i), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.dbg_addr    = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.ready",   {31'd0, bus.instr_ready}, 32'd1);
    check("rst.done",    {31'd0, bus.done},        32'd0);
    check("rst.illegal", {31'd0, bus.illegal},     32'd0);
    check("rst.wb_addr", {27'd0, bus.wb_addr},     32'd0);
    check("rst.wb_data", bus.wb_data,              32'd0);
    check("rst.opcode",  {28'd0, bus.alu_opcode},  32'd0);
    check_all_zero("rst.dbg");
    tick();
    check("idle.ready", {31'd0, bus.instr_ready}, 32'd1);
    check("idle.done",  {31'd0, bus.done},        32'd0);

    // LUI r1, 0x1234
    run("lui", enc_i(4'd11, 5'd1, 5'd0, 16'h1234), 4'd11, 32'h0, 32'h0000_1234, 5'd1,
        32'h1234_0000, 1'b0, 1'b0);
    check_reg("lui.r1", 5'd1, 32'h1234_0000);

    // OR r2, r0, #0x00FF
    run("ori", enc_i(4'd3, 5'd2, 5'd0, 16'h00FF), 4'd3, 32'h0, 32'h0000_00FF, 5'd2,
        32'h0000_00FF, 1'b0, 1'b0);
    check_reg("ori.r2", 5'd2, 32'h0000_00FF);

    // Back-to-back with instr_valid held: SUB r3,r1,r2 then SLT r4,r2,r1
    run("sub", enc_r(4'd1, 5'd3, 5'd1, 5'd2), 4'd1, 32'h1234_0000, 32'h0000_00FF, 5'd3,
        32'h1233_FF01, 1'b0, 1'b1);
    run("slt", enc_r(4'd9, 5'd4, 5'd2, 5'd1), 4'd9, 32'h0000_00FF, 32'h1234_0000, 5'd4,
        32'h0000_0001, 1'b0, 1'b0);
    check_reg("b2b.r3", 5'd3, 32'h1233_FF01);
    check_reg("b2b.r4", 5'd4, 32'h0000_0001);
    check_reg("b2b.r1", 5'd1, 32'h1234_0000);

    // ADD r0, r1, r1: computed but not written
    run("add_r0", enc_r(4'd0, 5'd0, 5'd1, 5'd1), 4'd0, 32'h1234_0000, 32'h1234_0000, 5'd0,
        32'h2468_0000, 1'b0, 1'b0);
    check_reg("add_r0.r0", 5'd0, 32'h0);

    // Illegal func 14 targeting r6
    run("ill", enc_r(4'd14, 5'd6, 5'd1, 5'd1), 4'hF, 32'h1234_0000, 32'h1234_0000, 5'd6,
        32'h0, 1'b1, 1'b0);
    check_reg("ill.r6", 5'd6, 32'h0);
    check_reg("ill.r4", 5'd4, 32'h0000_0001);

    // Reset during EXECUTE of ADD r5, r1, r1
    bus.instr       = enc_r(4'd0, 5'd5, 5'd1, 5'd1);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    check("abort.opcode_ex", {28'd0, bus.alu_opcode}, 32'd0);
    check("abort.a_ex",      bus.alu_a,               32'h1234_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.ready",   {31'd0, bus.instr_ready}, 32'd1);
    check("abort.done",    {31'd0, bus.done},        32'd0);
    check("abort.wb_data", bus.wb_data,              32'd0);
    check("abort.alu_a",   bus.alu_a,                32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("abort.no_done%0d", i), {31'd0, bus.done}, 32'd0);
    end
    check_all_zero("abort.dbg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
